// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: PIPE has priority; DMA wins when idle pipe or starved MAX_WAIT cycles.
// Grant is combinational (0 cycles); read data returns 2 edges later; losers see Pipe_Stall / ~Dma_Ready.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 7
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          Pipe_Req,
  input  logic          Pipe_We,
  input  logic [AW-1:0] Pipe_Addr,
  input  logic [DW-1:0] Pipe_WData,
  output logic          Pipe_Stall,
  output logic [DW-1:0] Pipe_RData,
  output logic          Pipe_RValid,
  input  logic          Dma_Valid,
  input  logic          Dma_We,
  input  logic [AW-1:0] Dma_Addr,
  input  logic [DW-1:0] Dma_WData,
  output logic          Dma_Ready,
  output logic [DW-1:0] Dma_RData,
  output logic          Dma_RValid,
  output logic          Mem_En,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  input  logic [DW-1:0] Mem_RData,
  output logic [7:0]    Wait_Cnt
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic [7:0] waitCnt;
  owner_e     rdOwner;
  logic       forceDma;
  logic       dmaGrant;
  logic       pipeGrant;

  // Reset holds the grant at NONE so nothing reaches memory while RST_N is low.
  always_comb begin
    forceDma  = (waitCnt == MaxWait);
    dmaGrant  = RST_N & Dma_Valid & (~Pipe_Req | forceDma);
    pipeGrant = RST_N & Pipe_Req & ~dmaGrant;
  end

  always_comb begin
    Mem_En    = pipeGrant | dmaGrant;
    Mem_We    = 1'b0;
    Mem_Addr  = '0;
    Mem_WData = '0;
    if (pipeGrant) begin
      Mem_We    = Pipe_We;
      Mem_Addr  = Pipe_Addr;
      Mem_WData = Pipe_WData;
    end else if (dmaGrant) begin
      Mem_We    = Dma_We;
      Mem_Addr  = Dma_Addr;
      Mem_WData = Dma_WData;
    end
  end

  assign Pipe_Stall = Pipe_Req & ~pipeGrant;
  assign Dma_Ready  = dmaGrant;
  assign Wait_Cnt   = waitCnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      waitCnt     <= '0;
      rdOwner     <= OWN_NONE;
      Pipe_RData  <= '0;
      Pipe_RValid <= 1'b0;
      Dma_RData   <= '0;
      Dma_RValid  <= 1'b0;
    end else begin
      if (!Dma_Valid || dmaGrant) begin
        waitCnt <= '0;
      end else if (waitCnt != MaxWait) begin
        waitCnt <= waitCnt + 8'd1;
      end

      if (pipeGrant && !Pipe_We) begin
        rdOwner <= OWN_PIPE;
      end else if (dmaGrant && !Dma_We) begin
        rdOwner <= OWN_DMA;
      end else begin
        rdOwner <= OWN_NONE;
      end

      // Memory data for last cycle's read is steered to whoever issued it.
      Pipe_RValid <= (rdOwner == OWN_PIPE);
      Dma_RValid  <= (rdOwner == OWN_DMA);
      if (rdOwner == OWN_PIPE) begin
        Pipe_RData <= Mem_RData;
      end
      if (rdOwner == OWN_DMA) begin
        Dma_RData <= Mem_RData;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port data-memory arbiter between the pipeline MEM stage and a DMA/loader port. It grants one access per cycle to the 1024-word synchronous data memory and stalls the pipeline when the DMA port holds the grant. A starvation counter guarantees DMA progress, and a one-deep return tracker steers read data back to the requester that issued the read.

## Interface
- AW, 10, word-address width (memory depth 2^AW words)
- DW, 32, data width
- MAX_WAIT, 7, consecutive DMA-blocked cycles before DMA is forced to win (1..255)
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- Pipe_Req  in  1  MEM-stage access request (MemRead | MemWrite)
- Pipe_We  in  1  1 = write, 0 = read
- Pipe_Addr  in  AW  word address
- Pipe_WData  in  DW  write data
- Pipe_Stall  out  1  combinational; Pipe_Req & ~pipe_grant
- Pipe_RData  out  DW  read data, registered
- Pipe_RValid  out  1  1-cycle pulse, Pipe_RData valid
- Dma_Valid  in  1  DMA request valid; must hold its fields until Dma_Ready
- Dma_We  in  1  1 = write
- Dma_Addr  in  AW  word address
- Dma_WData  in  DW  write data
- Dma_Ready  out  1  combinational; DMA beat accepted this cycle
- Dma_RData  out  DW  read data, registered
- Dma_RValid  out  1  1-cycle pulse
- Mem_En, Mem_We  out  1  memory strobes, combinational from grant
- Mem_Addr  out  AW; Mem_WData  out  DW  muxed from the granted requester
- Mem_RData  in  DW  memory read data, valid the cycle after the read
- Wait_Cnt  out  8  debug: current starvation count

## Operation
- Each cycle grants exactly one of PIPE, DMA, or NONE.
- Default priority is PIPE. DMA is granted when Dma_Valid & (~Pipe_Req | force).
- force = (wait_cnt == MAX_WAIT).
- wait_cnt increments when Dma_Valid & ~Dma_Ready. It clears on any DMA grant or when Dma_Valid = 0. It saturates at MAX_WAIT.
- On a forced cycle: Dma_Ready = 1 and Pipe_Stall = 1. The pipeline holds its EX/MEM request, which is reissued next cycle and wins (wait_cnt = 0).
- Mem_En = pipe_grant | dma_grant. Mem_We is the granted requester's We. NONE drives Mem_En = 0, Mem_We = 0, and Mem_Addr/Mem_WData = 0.
- Return tracker register rd_owner[1:0] (NONE/PIPE/DMA) is set on a granted read and cleared otherwise.
- The cycle after a read, Mem_RData is copied into the owner's RData register on the following edge, and the owner's RValid pulses for 1 cycle. The other RData register holds its value.

## Timing
- Request-to-grant is 0 cycles (combinational). Read data appears in RData/RValid 2 edges after the grant edge: memory edge, then capture edge.
- A write commits on the grant edge. A read of the same address granted the following cycle returns the new data.
- Back-to-back reads alternating PIPE and DMA return in issue order, one per cycle, with no bubble.
- Reset values: Pipe_RData = 0, Dma_RData = 0, Pipe_RValid = 0, Dma_RValid = 0, wait_cnt = 0, rd_owner = NONE.
- With RST_N low, the grant is forced to NONE: Mem_En = 0, Dma_Ready = 0, Pipe_Stall = Pipe_Req.
- Reset asserted mid-read drops the in-flight return; no RValid is produced after deassertion.
- Pipe_Req & Pipe_We & Dma_Valid & force: the DMA beat proceeds and the pipe write waits, with no memory corruption.
- MAX_WAIT = 1: DMA wins at most every other cycle under a continuous pipe request.

## Test plan
- Idle to single pipe read of addr 5 (memory holds 0xDEADBEEF): Mem_En = 1 in cycle 0; Pipe_RValid = 1 with Pipe_RData = 0xDEADBEEF after the 2nd edge; Pipe_Stall = 0 throughout.
- Simultaneous Pipe_Req and Dma_Valid for 1 cycle: pipe granted, Pipe_Stall = 0, Dma_Ready = 0, Wait_Cnt = 1. The next cycle with pipe idle grants DMA and Wait_Cnt returns to 0.
- Continuous pipe requests with continuous DMA, MAX_WAIT = 7: Dma_Ready pulses on exactly 1 of every 8 cycles, Pipe_Stall equals Dma_Ready on those cycles, and Wait_Cnt never exceeds 7.
- DMA write 0x12345678 to addr 0x3FF, then pipe read of 0x3FF the next cycle: Pipe_RData = 0x12345678, and Dma_RValid never pulses.
- Alternating PIPE read of addr 1 and DMA read of addr 2 for 4 cycles: RValid pulses alternate PIPE, DMA, PIPE, DMA, each carrying its own address's data.
- RST_N pulled low for 1 cycle between a pipe read grant and its capture edge: no Pipe_RValid; all outputs at reset values; normal arbitration resumes on the first edge after release.
